// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters.
// Each granted byte is written with a one-cycle Tx_WR strobe, then the arbiter
// waits for Tx_BUSY to rise and fall before pulsing the owner's ack. A
// transmitter that never raises Tx_BUSY causes the byte to be dropped with err.
//
//   state     | meaning
//   IDLE      | transmitter free of us; arbitrate when Tx_BUSY=0 and a req is up
//   ISSUE     | Tx_WR high for this single cycle, timeout counter cleared
//   WAIT_BUSY | waiting for the transmitter to accept (bounded by BUSY_TIMEOUT)
//   WAIT_DONE | transmitter shifting the frame out, wait for Tx_BUSY to drop
//   DONE      | ack (and err on timeout) visible, last-served pointer updated
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [7:0]       data0,
  input  logic             req1,
  input  logic [7:0]       data1,
  input  logic             Tx_BUSY,
  output logic             Tx_WR,
  output logic [7:0]       Tx_DATA,
  output logic             ack0,
  output logic             ack1,
  output logic             err,
  output logic             grant,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  localparam int               TMO_W    = $clog2(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_q,    state_d;
  logic               tx_wr_q,    tx_wr_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               ack0_q,     ack0_d;
  logic               ack1_q,     ack1_d;
  logic               err_q,      err_d;
  logic               grant_q,    grant_d;
  logic               busy_q,     busy_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic               last_q,     last_d;
  logic [TMO_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
  logic               pick;

  // Next-state decode; all outputs are computed one cycle early so they leave registered.
  always_comb begin
    state_d    = state_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    grant_d    = grant_q;
    tx_count_d = tx_count_q;
    last_d     = last_q;
    tmo_cnt_d  = tmo_cnt_q;
    pick       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!Tx_BUSY && (req0 || req1)) begin
          // On a tie the requester that was not served last wins.
          pick      = (req0 && req1) ? ~last_q : req1;
          grant_d   = pick;
          tx_data_d = pick ? data1 : data0;
          tx_wr_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Transmitter never took the byte: drop it, no count.
          state_d = DONE;
          err_d   = 1'b1;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          state_d    = DONE;
          ack0_d     = ~grant_q;
          ack1_d     = grant_q;
          tx_count_d = tx_count_q + 1'b1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_count_q <= '0;
      last_q     <= 1'b1;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tx_count_q <= tx_count_d;
      last_q     <= last_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign Tx_WR    = tx_wr_q;
  assign Tx_DATA  = tx_data_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = err_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and a
// randomized run against an abstract arbitration / transmitter model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       Tx_BUSY;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       ack0, ack1, err, grant, busy;
  logic [3:0] tx_count;

  uart_tx_arbiter #(.BUSY_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .Tx_BUSY(Tx_BUSY), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
    .ack0(ack0), .ack1(ack1), .err(err), .grant(grant), .busy(busy),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int wr_at    = 0;

  // transmitter model controls
  bit tx_respond = 1'b1;
  bit tx_hold    = 1'b0;
  int tx_len     = 100;
  int dly        = 0;
  int bcnt       = 0;
  logic prev_wr  = 1'b0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       resp;
    logic       g;
    logic [7:0] dat;
    logic       e;
    logic [3:0] cnt;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, check invariants, advance the transmitter model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ack0 || ack1) chk("ack_exclusive", 32'(ack0 & ack1), 0);
    if (Tx_WR)        chk("wr_single_cycle", 32'(prev_wr), 0);
    if (err)          chk("err_with_ack", 32'(ack0 | ack1), 1);
    prev_wr = Tx_WR;
    if (tx_hold) Tx_BUSY = 1'b1;
    else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin Tx_BUSY = 1'b0; fall_cyc = cyc; end
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin Tx_BUSY = 1'b1; bcnt = tx_len; end
    end else Tx_BUSY = 1'b0;
    if (Tx_WR && tx_respond && !tx_hold) dly = 2;
  endtask

  task automatic wait_wr(input int budget);
    int   n     = 0;
    logic stray = 1'b0;
    do begin
      step(); n++;
      stray |= (ack0 | ack1);
    end while (!Tx_WR && n < budget);
    chk("wr_seen", 32'(Tx_WR), 1);
    chk("no_ack_before_wr", 32'(stray), 0);
    wr_at = cyc;
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    do begin
      step(); n++;
    end while (!(ack0 || ack1) && n < budget);
    chk("ack_seen", 32'(ack0 | ack1), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_Tx_WR"},    32'(Tx_WR), 0);
    chk({tag, "_Tx_DATA"},  32'(Tx_DATA), 0);
    chk({tag, "_ack0"},     32'(ack0), 0);
    chk({tag, "_ack1"},     32'(ack1), 0);
    chk({tag, "_err"},      32'(err), 0);
    chk({tag, "_grant"},    32'(grant), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_tx_count"}, 32'(tx_count), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0; step();
    reset = 1'b1; step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    bit         s0, s1, sbusy, exp_who, exp_err, in_flight;
    logic [7:0] sd0, sd1;
    int         model_cnt, age, max_age, n_wr;
    bit         model_last;

    //          r0    r1    d0     d1     resp  g     dat    e     cnt
    vt[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 4'd5};
    vt[1] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 4'd6};
    vt[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 8'h33, 1'b0, 4'd7};
    vt[3] = '{1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 8'h66, 1'b0, 4'd8};
    vt[4] = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 1'b0, 8'h77, 1'b1, 4'd8};
    vt[5] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b0, 4'd9};
    vt[6] = '{1'b0, 1'b1, 8'h00, 8'hBB, 1'b0, 1'b1, 8'hBB, 1'b1, 4'd9};
    vt[7] = '{1'b1, 1'b1, 8'hCC, 8'hDD, 1'b1, 1'b0, 8'hCC, 1'b0, 4'd10};

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00; Tx_BUSY = 1'b0;

    // reset state
    repeat (5) step();
    chk_reset_vals("rst");
    reset = 1'b1;
    step();

    // single byte, 100-cycle frame
    req0 = 1'b1; data0 = 8'h94;
    step();
    chk("p1_wr", 32'(Tx_WR), 1);
    chk("p1_data", 32'(Tx_DATA), 32'h94);
    chk("p1_grant", 32'(grant), 0);
    chk("p1_busy", 32'(busy), 1);
    step();
    chk("p1_wr_one_cycle", 32'(Tx_WR), 0);
    wait_ack(300);
    chk("p1_ack0", 32'(ack0), 1);
    chk("p1_err", 32'(err), 0);
    chk("p1_ack_after_fall", 32'(cyc - fall_cyc), 1);
    req0 = 1'b0;
    step();
    chk("p1_count", 32'(tx_count), 1);
    chk("p1_idle", 32'(busy), 0);

    // contention from reset: A1, 3C, A1, 3C
    pulse_reset();
    tx_len = 5;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hA1; data1 = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      wait_wr(20);
      chk("p2_data", 32'(Tx_DATA), (i % 2 == 1) ? 32'h3C : 32'hA1);
      wait_ack(100);
      chk("p2_ack0", 32'(ack0), (i % 2 == 0) ? 1 : 0);
      chk("p2_ack1", 32'(ack1), (i % 2 == 1) ? 1 : 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("p2_count", 32'(tx_count), 4);

    // vector table: one arbitration round per record
    for (int i = 0; i < 8; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; data0 = vt[i].d0; data1 = vt[i].d1;
      tx_respond = vt[i].resp;
      wait_wr(20);
      chk("tbl_grant", 32'(grant), 32'(vt[i].g));
      chk("tbl_data", 32'(Tx_DATA), 32'(vt[i].dat));
      wait_ack(100);
      chk("tbl_ack0", 32'(ack0), 32'(!vt[i].g));
      chk("tbl_ack1", 32'(ack1), 32'(vt[i].g));
      chk("tbl_err", 32'(err), 32'(vt[i].e));
      if (!vt[i].resp) chk("tbl_timeout_latency", 32'(cyc - wr_at), 9);
      req0 = 1'b0; req1 = 1'b0;
      step();
      chk("tbl_count", 32'(tx_count), 32'(vt[i].cnt));
    end

    // timeout on req0 while req1 becomes pending; req1 served next
    tx_respond = 1'b0;
    req0 = 1'b1; data0 = 8'hE0;
    wait_wr(20);
    chk("p4_data0", 32'(Tx_DATA), 32'hE0);
    req1 = 1'b1; data1 = 8'hE1;
    wait_ack(100);
    chk("p4_ack0", 32'(ack0), 1);
    chk("p4_err", 32'(err), 1);
    chk("p4_latency", 32'(cyc - wr_at), 9);
    req0 = 1'b0; tx_respond = 1'b1;
    step();
    chk("p4_count_kept", 32'(tx_count), 10);
    wait_wr(20);
    chk("p4_data1", 32'(Tx_DATA), 32'hE1);
    chk("p4_grant1", 32'(grant), 1);
    wait_ack(100);
    chk("p4_ack1", 32'(ack1), 1);
    chk("p4_err_clear", 32'(err), 0);
    req1 = 1'b0;
    step();
    chk("p4_count", 32'(tx_count), 11);

    // transmitter busy blocks arbitration
    tx_hold = 1'b1;
    step(); step();
    req1 = 1'b1; data1 = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p5_no_wr", 32'(Tx_WR), 0);
      chk("p5_not_busy", 32'(busy), 0);
    end
    tx_hold = 1'b0;
    step();
    chk("p5_wr_not_yet", 32'(Tx_WR), 0);
    step();
    chk("p5_wr", 32'(Tx_WR), 1);
    chk("p5_data", 32'(Tx_DATA), 32'h5A);
    chk("p5_grant", 32'(grant), 1);
    wait_ack(100);
    chk("p5_ack1", 32'(ack1), 1);
    req1 = 1'b0;
    step();
    chk("p5_count", 32'(tx_count), 12);

    // reset in the middle of a frame
    tx_len = 20;
    req0 = 1'b1; data0 = 8'hC3;
    wait_wr(20);
    chk("p6_data", 32'(Tx_DATA), 32'hC3);
    repeat (5) step();
    chk("p6_mid_frame", 32'(busy), 1);
    reset = 1'b0; req0 = 1'b0;
    step();
    chk_reset_vals("p6");
    reset = 1'b1; req0 = 1'b1; data0 = 8'hC4;
    wait_wr(100);
    chk("p6_wr_after_tx_free", 32'(cyc - fall_cyc), 1);
    chk("p6_data_new", 32'(Tx_DATA), 32'hC4);
    chk("p6_grant", 32'(grant), 0);
    wait_ack(100);
    chk("p6_ack0", 32'(ack0), 1);
    chk("p6_err", 32'(err), 0);
    req0 = 1'b0;
    step();
    chk("p6_count", 32'(tx_count), 1);

    // counter wrap: 17 bytes from zero
    pulse_reset();
    tx_len = 2;
    req0 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data0 = 8'(i + 8'h40);
      wait_wr(20);
      chk("p7_count_before", 32'(tx_count), 32'(i % 16));
      wait_ack(50);
    end
    req0 = 1'b0;
    step();
    chk("p7_count_wrapped", 32'(tx_count), 1);

    // randomized traffic against the abstract model
    pulse_reset();
    model_last = 1'b1; model_cnt = 0; in_flight = 1'b0;
    exp_who = 1'b0; exp_err = 1'b0; age = 0; max_age = 0; n_wr = 0;
    tx_respond = 1'b1; tx_len = 3;
    for (int k = 0; k < 3000; k++) begin
      s0 = req0; s1 = req1; sd0 = data0; sd1 = data1; sbusy = Tx_BUSY;
      step();
      if (in_flight) begin
        age++;
        if (age > max_age) max_age = age;
      end
      if (Tx_WR) begin
        exp_who = (s0 && s1) ? !model_last : s1;
        chk("rnd_req_present", 32'(s0 | s1), 1);
        chk("rnd_tx_free", 32'(sbusy), 0);
        chk("rnd_grant", 32'(grant), 32'(exp_who));
        chk("rnd_data", 32'(Tx_DATA), exp_who ? 32'(sd1) : 32'(sd0));
        chk("rnd_count", 32'(tx_count), 32'(model_cnt));
        exp_err = !tx_respond; in_flight = 1'b1; age = 0; n_wr++;
      end
      if (ack0 || ack1) begin
        chk("rnd_in_flight", 32'(in_flight), 1);
        chk("rnd_ack_who", 32'({ack1, ack0}), exp_who ? 32'h2 : 32'h1);
        chk("rnd_err", 32'(err), 32'(exp_err));
        if (!exp_err) model_cnt = (model_cnt + 1) % 16;
        model_last = exp_who; in_flight = 1'b0;
        if (exp_who == 1'b0) begin
          if ($urandom_range(1, 0) == 1) data0 = 8'($urandom); else req0 = 1'b0;
        end else begin
          if ($urandom_range(1, 0) == 1) data1 = 8'($urandom); else req1 = 1'b0;
        end
        tx_respond = ($urandom_range(7, 0) != 0);
        tx_len     = $urandom_range(6, 1);
      end
      if (!req0 && $urandom_range(3, 0) == 0) begin req0 = 1'b1; data0 = 8'($urandom); end
      if (!req1 && $urandom_range(3, 0) == 0) begin req1 = 1'b1; data1 = 8'($urandom); end
    end
    chk("rnd_progress", 32'(n_wr > 50), 1);
    chk("rnd_max_latency", 32'(max_age < 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
